vga_rect_filler: RTL and testbench

Rectangle-fill drawing engine that sits directly upstream of the VGA adapter's framebuffer write port. It accepts one rectangle command per handshake (origin, size, colour) from the game/board-rendering logic. It then emits one framebuffer write per clock (`plot_x`, `plot_y`, `plot_colour`, `plot`) in raster order until the rectangle is covered. The scan-out controller reads those pixels back from the framebuffer. Default geometry is 160x120 with 3-bit colour.

---
 rtl/vga_rect_filler.sv | 117 +++++++++++
 tb/tb_vga_rect_filler.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rect_filler.sv
// Rectangle-fill engine: accepts one (x, y, w, h, colour) command and emits one
// framebuffer write per clock in raster order. Optional clipping: VGA_RECT_CLIP_EN.
module vga_rect_filler #(
    parameter int X_WIDTH      = 8,
    parameter int Y_WIDTH      = 7,
    parameter int COLOUR_WIDTH = 3,
    parameter int SCREEN_W     = 160,
    parameter int SCREEN_H     = 120
) (
    input  logic                    vga_clock,
    input  logic                    resetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [X_WIDTH-1:0]      cmd_x,
    input  logic [Y_WIDTH-1:0]      cmd_y,
    input  logic [X_WIDTH-1:0]      cmd_w,
    input  logic [Y_WIDTH-1:0]      cmd_h,
    input  logic [COLOUR_WIDTH-1:0] cmd_colour,
    output logic [X_WIDTH-1:0]      plot_x,
    output logic [Y_WIDTH-1:0]      plot_y,
    output logic [COLOUR_WIDTH-1:0] plot_colour,
    output logic                    plot,
    output logic                    busy,
    output logic                    done
);

    localparam logic [X_WIDTH-1:0] X_ONE      = X_WIDTH'(1);
    localparam logic [Y_WIDTH-1:0] Y_ONE      = Y_WIDTH'(1);
    localparam logic [X_WIDTH:0]   SCREEN_W_L = (X_WIDTH+1)'(SCREEN_W);
    localparam logic [Y_WIDTH:0]   SCREEN_H_L = (Y_WIDTH+1)'(SCREEN_H);

`ifdef VGA_RECT_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [X_WIDTH-1:0]      x0_q, w_q, cx_q, cx_d;
    logic [Y_WIDTH-1:0]      y0_q, h_q, cy_q, cy_d;
    logic [COLOUR_WIDTH-1:0] colour_q;

    logic               last_col, last_row, drawing, in_screen;
    logic [X_WIDTH:0]   sum_x;
    logic [Y_WIDTH:0]   sum_y;

    assign last_col = (cx_q == w_q - X_ONE);
    assign last_row = (cy_q == h_q - Y_ONE);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cx_d = cx_q + X_ONE;
        cy_d = cy_q;
        if (last_col) begin
            cx_d = '0;
            cy_d = cy_q + Y_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    // NOTE: the command registers are tiny flops, not a RAM, so resetting them costs nothing.
    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            colour_q <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        x0_q     <= cmd_x;
                        y0_q     <= cmd_y;
                        w_q      <= cmd_w;
                        h_q      <= cmd_h;
                        colour_q <= cmd_colour;
                        cx_q     <= '0;
                        cy_q     <= '0;
                        state_q  <= (cmd_w == '0 || cmd_h == '0) ? S_DONE : S_DRAW;
                    end
                end
                S_DRAW: begin
                    cx_q <= cx_d;
                    cy_q <= cy_d;
                    if (last_col && last_row) state_q <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Unwrapped sums keep the carry so clipping can see coordinates past the screen edge.
    assign sum_x     = {1'b0, x0_q} + {1'b0, cx_q};
    assign sum_y     = {1'b0, y0_q} + {1'b0, cy_q};
    assign in_screen = (sum_x < SCREEN_W_L) && (sum_y < SCREEN_H_L);
    assign drawing   = (state_q == S_DRAW);

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign plot        = drawing && (!CLIP_EN || in_screen);
    assign plot_x      = drawing ? sum_x[X_WIDTH-1:0] : '0;
    assign plot_y      = drawing ? sum_y[Y_WIDTH-1:0] : '0;
    assign plot_colour = drawing ? colour_q : '0;

endmodule

// File: tb/tb_vga_rect_filler.sv
// Self-checking bench for vga_rect_filler: a per-cycle expected-output queue built
// from rectangle geometry, plus literal checks of the directed scenarios.
module tb_vga_rect_filler;

    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;
    localparam int SW = 160;
    localparam int SH = 120;

    logic          vga_clock = 1'b0;
    logic          resetn    = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [XW-1:0] cmd_x = '0, cmd_w = '0;
    logic [YW-1:0] cmd_y = '0, cmd_h = '0;
    logic [CW-1:0] cmd_colour = '0;
    logic [XW-1:0] plot_x;
    logic [YW-1:0] plot_y;
    logic [CW-1:0] plot_colour;
    logic          plot, busy, done;

    vga_rect_filler dut (
        .vga_clock   (vga_clock),
        .resetn      (resetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_x       (cmd_x),
        .cmd_y       (cmd_y),
        .cmd_w       (cmd_w),
        .cmd_h       (cmd_h),
        .cmd_colour  (cmd_colour),
        .plot_x      (plot_x),
        .plot_y      (plot_y),
        .plot_colour (plot_colour),
        .plot        (plot),
        .busy        (busy),
        .done        (done)
    );

    always #5 vga_clock = ~vga_clock;

    // {cmd_ready, busy, done, plot, plot_x, plot_y, plot_colour}
    typedef logic [4+XW+YW+CW-1:0] rec_t;

    typedef struct {
        int x;
        int y;
        int c;
        int cyc;
    } pix_t;

    rec_t exp_q[$];
    pix_t plot_log[$];
    int   done_log[$];
    int   acc_log[$];
    bit   cur_idle = 1'b1;
    int   cyc      = 0;
    int   n_acc    = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic rec_t mk(input bit r, input bit b, input bit d, input bit p,
                                input int x, input int y, input int c);
        logic [XW-1:0] px;
        logic [YW-1:0] py;
        logic [CW-1:0] pc;
        px = XW'(x % (1 << XW));
        py = YW'(y % (1 << YW));
        pc = CW'(c);
        return {r, b, d, p, px, py, pc};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Expected output of every cycle a command occupies: w*h pixel slots then one done slot.
    function automatic void model_cmd(input int x, input int y, input int w, input int h, input int c);
        bit vis;
        for (int r = 0; r < h; r++) begin
            for (int col = 0; col < w; col++) begin
`ifdef VGA_RECT_CLIP_EN
                vis = (x + col < SW) && (y + r < SH);
`else
                vis = 1'b1;
`endif
                exp_q.push_back(mk(0, 1, 0, vis, x + col, y + r, c));
            end
        end
        exp_q.push_back(mk(0, 1, 1, 0, 0, 0, 0));
    endfunction

    function automatic int q0(input int q[$]);
        return (q.size() > 0) ? q[0] : -999;
    endfunction

    always @(posedge vga_clock) begin
        cyc++;
        if (resetn && cur_idle && cmd_valid) begin
            model_cmd(int'(cmd_x), int'(cmd_y), int'(cmd_w), int'(cmd_h), int'(cmd_colour));
            acc_log.push_back(cyc);
            n_acc++;
        end
    end

    always @(negedge vga_clock) begin
        rec_t a, e;
        a = {cmd_ready, busy, done, plot, plot_x, plot_y, plot_colour};
        if (!resetn) begin
            exp_q.delete();
            e = mk(1, 0, 0, 0, 0, 0, 0);
            cur_idle = 1'b1;
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cur_idle = 1'b0;
        end else begin
            e = mk(1, 0, 0, 0, 0, 0, 0);
            cur_idle = 1'b1;
        end
        check("cycle_outputs", 32'(a), 32'(e));
        if (plot) plot_log.push_back('{int'(plot_x), int'(plot_y), int'(plot_colour), cyc});
        if (done) done_log.push_back(cyc);
    end

    task automatic set_cmd(input int x, input int y, input int w, input int h, input int c);
        cmd_x      = XW'(x);
        cmd_y      = YW'(y);
        cmd_w      = XW'(w);
        cmd_h      = YW'(h);
        cmd_colour = CW'(c);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge vga_clock);
        #1;
    endtask

    task automatic wait_accept(input int target);
        int k;
        k = 0;
        while (n_acc < target && k < 30000) begin
            @(posedge vga_clock);
            #1;
            k++;
        end
        check("accept_timeout", 32'(n_acc >= target), 32'd1);
    endtask

    task automatic clear_logs();
        plot_log.delete();
        done_log.delete();
        acc_log.delete();
    endtask

    task automatic run_cmd(input int x, input int y, input int w, input int h, input int c);
        clear_logs();
        set_cmd(x, y, w, h, c);
        cmd_valid = 1'b1;
        wait_accept(n_acc + 1);
        cmd_valid = 1'b0;
        idle_cycles(w * h + 3);
    endtask

    initial begin
        int xs[4];
        int ys[4];
        int t;

        resetn = 1'b0;
        idle_cycles(3);
        check("reset_outputs", 32'({cmd_ready, busy, done, plot, plot_x, plot_y, plot_colour}),
              32'(mk(1, 0, 0, 0, 0, 0, 0)));
        resetn = 1'b1;
        idle_cycles(2);

        // Basic 2x2 fill
        run_cmd(10, 5, 2, 2, 4);
        xs = '{10, 11, 10, 11};
        ys = '{5, 5, 6, 6};
        check("basic_count", 32'(plot_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < plot_log.size(); i++) begin
            check("basic_pixel", 32'((plot_log[i].x << 16) | (plot_log[i].y << 8) | plot_log[i].c),
                  32'((xs[i] << 16) | (ys[i] << 8) | 4));
            check("basic_slot", 32'(plot_log[i].cyc - q0(acc_log)), 32'(i));
        end
        check("basic_done_count", 32'(done_log.size()), 32'd1);
        check("basic_done_cyc", 32'(q0(done_log) - q0(acc_log)), 32'd4);

        // Empty commands: w == 0, then h == 0
        run_cmd(3, 3, 0, 7, 1);
        check("empty_w_plots", 32'(plot_log.size()), 32'd0);
        check("empty_w_done", 32'(q0(done_log) - q0(acc_log)), 32'd0);
        run_cmd(3, 3, 5, 0, 2);
        check("empty_h_plots", 32'(plot_log.size()), 32'd0);
        check("empty_h_done", 32'(q0(done_log) - q0(acc_log)), 32'd0);

        // Rectangle running past the bottom-right screen corner
        run_cmd(158, 119, 4, 2, 7);
        check("clip_done_cyc", 32'(q0(done_log) - q0(acc_log)), 32'd8);
`ifdef VGA_RECT_CLIP_EN
        check("clip_count", 32'(plot_log.size()), 32'd2);
        if (plot_log.size() == 2) begin
            check("clip_px0", 32'((plot_log[0].x << 8) | plot_log[0].y), 32'((158 << 8) | 119));
            check("clip_px1", 32'((plot_log[1].x << 8) | plot_log[1].y), 32'((159 << 8) | 119));
        end
`else
        check("clip_count", 32'(plot_log.size()), 32'd8);
        if (plot_log.size() == 8) begin
            check("clip_px3", 32'((plot_log[3].x << 8) | plot_log[3].y), 32'((161 << 8) | 119));
            check("clip_px4", 32'((plot_log[4].x << 8) | plot_log[4].y), 32'((158 << 8) | 120));
        end
`endif

        // Coordinate wrap at the register widths
        run_cmd(254, 126, 4, 3, 1);
`ifdef VGA_RECT_CLIP_EN
        check("wrap_count", 32'(plot_log.size()), 32'd0);
`else
        check("wrap_count", 32'(plot_log.size()), 32'd12);
        if (plot_log.size() == 12) begin
            check("wrap_x", 32'(plot_log[2].x), 32'd0);
            check("wrap_y", 32'((plot_log[8].x << 8) | plot_log[8].y), 32'((254 << 8) | 0));
        end
`endif

        // Back-to-back with cmd_valid held high and data changing mid-draw
        clear_logs();
        t = n_acc;
        set_cmd(20, 30, 3, 2, 5);
        cmd_valid = 1'b1;
        wait_accept(t + 1);
        set_cmd(1, 2, 2, 1, 2);
        wait_accept(t + 2);
        cmd_valid = 1'b0;
        idle_cycles(6);
        check("b2b_count", 32'(plot_log.size()), 32'd8);
        check("b2b_gap", 32'((acc_log.size() == 2) ? acc_log[1] - acc_log[0] : -1), 32'd8);
        check("b2b_done_cyc", 32'(q0(done_log) - q0(acc_log)), 32'd6);
        if (plot_log.size() == 8) begin
            check("b2b_colour_a", 32'(plot_log[5].c), 32'd5);
            check("b2b_colour_b", 32'(plot_log[6].c), 32'd2);
        end

        // Reset asserted during the third pixel slot of a 4x4 fill
        clear_logs();
        set_cmd(40, 50, 4, 4, 6);
        cmd_valid = 1'b1;
        wait_accept(n_acc + 1);
        cmd_valid = 1'b0;
        idle_cycles(2);
        resetn = 1'b0;
        #1;
        check("rst_async", 32'({plot, done, cmd_ready, busy}), 32'b0010);
        idle_cycles(1);
        resetn = 1'b1;
        idle_cycles(3);
        check("rst_plots", 32'(plot_log.size()), 32'd2);
        check("rst_no_done", 32'(done_log.size()), 32'd0);
        run_cmd(0, 0, 3, 1, 3);
        check("post_rst_count", 32'(plot_log.size()), 32'd3);
        if (plot_log.size() == 3)
            check("post_rst_px2", 32'((plot_log[2].x << 16) | (plot_log[2].y << 8) | plot_log[2].c),
                  32'((2 << 16) | 3));

        // Full screen
        run_cmd(0, 0, SW, SH, 7);
        check("full_count", 32'(plot_log.size()), 32'(SW * SH));
        if (plot_log.size() > 0)
            check("full_last", 32'((plot_log[$].x << 8) | plot_log[$].y), 32'((159 << 8) | 119));
        check("full_done_cyc", 32'(q0(done_log) - q0(acc_log)), 32'(SW * SH));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
